byte_ram_sync_loader: RTL and testbench
=======================================

# byte_ram_sync_loader

Parametrised, byte-addressed, big-endian single-port RAM with registered read, byte/half/word access sizes with sign/zero extension, and a built-in sequential loader that fills memory from a byte stream (e.g. UART receiver) before execution. It replaces the plain async instruction/data memory between the debug/loader path and the pipeline's fetch or memory stage.

## Interface
- ADDR_WIDTH, 12: byte-address width; depth = 2**ADDR_WIDTH bytes.
- BYTE_WIDTH, 8: bits per addressable byte.
- WORD_BYTES, 4: bytes per word (power of two, ≥2); WORD = BYTE_WIDTH*WORD_BYTES.

- i_clk  in  1  single clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_load_start  in  1  start a load session (honoured only in IDLE).
- i_load_count  in  ADDR_WIDTH+1  number of bytes to load, sampled with i_load_start.
- i_load_valid  in  1  loader byte valid.
- i_load_byte  in  BYTE_WIDTH  loader byte.
- o_load_ready  out  1  loader can accept a byte (high only in LOAD).
- o_load_done  out  1  one-cycle pulse at end of load session.
- o_busy  out  1  high in LOAD and DONE; access port ignored.
- i_req_valid  in  1  access request.
- i_we  in  1  1 = write, 0 = read.
- i_size  in  2  00 byte, 01 half (2 bytes), 10 word; 11 treated as word.
- i_unsigned  in  1  reads: 1 zero-extend, 0 sign-extend (byte/half only).
- i_addr  in  ADDR_WIDTH  byte address of lowest (most significant) byte.
- i_wdata  in  WORD  write data, right-aligned for byte/half.
- o_rdata  out  WORD  registered read data.
- o_rvalid  out  1  one-cycle pulse, o_rdata valid.
- o_misaligned  out  1  one-cycle pulse, request rejected.

## Operation
- Endianness: big-endian; byte at i_addr is MSB of the accessed unit.
- States: IDLE, LOAD, DONE.
  - IDLE: i_load_start=1 → capture count, pointer=0; count≠0 → LOAD, count=0 → DONE.
  - LOAD: each i_load_valid&&o_load_ready writes i_load_byte at pointer, pointer+1, remaining−1; accepting last byte → DONE.
  - DONE: o_load_done=1 for exactly one cycle → IDLE.
- i_load_start outside IDLE ignored. Counts >2**ADDR_WIDTH clamp to 2**ADDR_WIDTH; pointer never wraps.
- Access port active only in IDLE; requests while o_busy=1 are dropped (no rvalid, no write, no error).
- Write: byte writes i_wdata[BYTE_WIDTH-1:0]; half writes low 2 bytes; word writes all WORD_BYTES bytes.
- Read: byte/half extended per i_unsigned to WORD; word returned as is.
- Misaligned (see Configuration): half with i_addr[0]=1, word with i_addr[log2(WORD_BYTES)-1:0]≠0 → no memory change, o_misaligned pulse, no o_rvalid.
- Memory contents not cleared by reset; uninitialised contents are X.

## Timing
- Reset values: state IDLE, o_load_ready 0, o_load_done 0, o_busy 0, o_rvalid 0, o_misaligned 0, o_rdata 0, pointer 0.
- Read latency 1: request at edge N → o_rdata/o_rvalid valid after edge N+1 for one cycle; o_rdata holds until next read.
- Write takes effect at the request edge; read issued the next cycle returns new data.
- o_misaligned asserted the cycle after the offending request (same slot as o_rvalid would be).
- Loader: one byte per cycle max; o_load_ready high the cycle after i_load_start, low in DONE.
- N-byte load with continuous valid: LOAD for N cycles, o_load_done in cycle N+1, o_busy falls the cycle after.
- Reset mid-load: next cycle IDLE, ready/busy 0, no o_load_done; bytes already written remain.

## Configuration
- RAM_MISALIGN_CHECK_EN defined: misalignment detection and o_misaligned as in Operation.
- Not defined: low address bits forced to zero for half/word (access rounded down to aligned boundary, completes normally); o_misaligned tied 0.

## Test plan
- Load 8 bytes 0x01..0x08 back-to-back from start count=8 → o_load_done pulses 9 cycles after start; word read @0 = 0x01020304, @4 = 0x05060708, rvalid 1 cycle after request.
- Byte read @3 after writing byte 0x80 there: i_unsigned=0 → 0xFFFFFF80, i_unsigned=1 → 0x00000080; half read @2 with bytes 0x03,0x80 signed → 0x00000380.
- Half write 0xBEEF @6 then word read @4 → 0x0506BEEF; requests during LOAD produce no rvalid and no write.
- With RAM_MISALIGN_CHECK_EN: word write @5 → o_misaligned 1 cycle later, memory @4 unchanged; without macro same write lands at @4.
- Loader gaps: valid toggled every other cycle for count=3 → exactly 3 bytes written, done only after third; start with count=0 → o_load_done next cycle, nothing written.
- Reset asserted after 2 of 4 load bytes → IDLE next cycle, no done pulse, bytes 0–1 retained, new start accepted immediately.

Source files
------------

// File: rtl/byte_ram_sync_loader.sv
// ---------------------------------------------------------------------------
// byte_ram_sync_loader
//
// Byte-addressed, big-endian, single-port RAM with a registered read port and
// a built-in sequential loader that fills memory from a byte stream (for
// example a UART receiver) before the pipeline starts executing.
//
// Memory organisation: WORD_BYTES byte lanes, each its own inferred RAM array
// of 2**ADDR_WIDTH / WORD_BYTES rows. Lane k holds the bytes whose address
// satisfies addr % WORD_BYTES == k. Because accesses are always aligned, a
// byte, half or word access touches one row across a subset of the lanes.
// Lane 0 is the most significant byte of a word (big-endian).
//
// Optional feature (compile-time macro RAM_MISALIGN_CHECK_EN):
//   defined     - misaligned half/word requests are rejected with a one-cycle
//                 o_misaligned pulse; memory is untouched and no o_rvalid.
//   not defined - low address bits are forced to zero for half/word, so the
//                 access is rounded down to its aligned boundary and
//                 completes normally; o_misaligned is tied low.
//
// Ports
//   i_clk          clock, all logic on the rising edge
//   i_reset        synchronous active-high reset
//   i_load_start   start a load session (honoured only in IDLE)
//   i_load_count   bytes to load, sampled with i_load_start (clamped to depth)
//   i_load_valid   loader byte valid
//   i_load_byte    loader byte
//   o_load_ready   loader can accept a byte (LOAD state only)
//   o_load_done    one-cycle pulse at the end of a load session
//   o_busy         loader owns the memory; access requests are dropped
//   i_req_valid    access request
//   i_we           1 = write, 0 = read
//   i_size         00 byte, 01 half, 10/11 word
//   i_unsigned     reads: 1 zero-extend, 0 sign-extend (byte/half)
//   i_addr         byte address of the most significant byte accessed
//   i_wdata        write data, right-aligned for byte/half
//   o_rdata        registered read data, holds until the next read
//   o_rvalid       one-cycle pulse, o_rdata valid
//   o_misaligned   one-cycle pulse, request rejected
// ---------------------------------------------------------------------------
module byte_ram_sync_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int BYTE_WIDTH = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_load_start,
    input  logic [ADDR_WIDTH:0]              i_load_count,
    input  logic                             i_load_valid,
    input  logic [BYTE_WIDTH-1:0]            i_load_byte,
    output logic                             o_load_ready,
    output logic                             o_load_done,
    output logic                             o_busy,
    input  logic                             i_req_valid,
    input  logic                             i_we,
    input  logic [1:0]                       i_size,
    input  logic                             i_unsigned,
    input  logic [ADDR_WIDTH-1:0]            i_addr,
    input  logic [BYTE_WIDTH*WORD_BYTES-1:0] i_wdata,
    output logic [BYTE_WIDTH*WORD_BYTES-1:0] o_rdata,
    output logic                             o_rvalid,
    output logic                             o_misaligned
);

    localparam int WORD_WIDTH = BYTE_WIDTH * WORD_BYTES;
    localparam int LANE_BITS  = $clog2(WORD_BYTES);
    localparam int ROW_BITS   = ADDR_WIDTH - LANE_BITS;
    localparam int ROWS       = 2 ** ROW_BITS;

    localparam logic [ADDR_WIDTH:0] DEPTH_BYTES = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE     = (ADDR_WIDTH + 1)'(1);
    localparam logic [LANE_BITS:0]  FULL_BYTES  = (LANE_BITS + 1)'(WORD_BYTES);
    localparam logic [LANE_BITS:0]  NB_ONE      = (LANE_BITS + 1)'(1);
    localparam logic [LANE_BITS:0]  NB_TWO      = (LANE_BITS + 1)'(2);

    // -----------------------------------------------------------------------
    // Loader FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_WIDTH:0] remaining_reg;
    // One bit wider than the address so it can reach the full depth without
    // wrapping back onto byte 0.
    logic [ADDR_WIDTH:0] ptr_reg;
    logic                load_we;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            ptr_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && i_load_start) begin
                remaining_reg <= (i_load_count > DEPTH_BYTES) ? DEPTH_BYTES : i_load_count;
                ptr_reg       <= '0;
            end else if (load_we) begin
                ptr_reg       <= ptr_reg + CNT_ONE;
                remaining_reg <= remaining_reg - CNT_ONE;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        load_we      = 1'b0;
        o_load_ready = 1'b0;
        o_load_done  = 1'b0;
        o_busy       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_load_start) begin
                    state_next = (i_load_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_load_ready = 1'b1;
                o_busy       = 1'b1;
                // The pointer MSB guard keeps a write from ever landing past
                // the last byte.
                if (i_load_valid && !ptr_reg[ADDR_WIDTH]) begin
                    load_we = 1'b1;
                    if (remaining_reg == CNT_ONE) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                o_load_done = 1'b1;
                o_busy      = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Access request decode
    // -----------------------------------------------------------------------
    logic                  req_ok;
    logic [LANE_BITS:0]    acc_bytes;     // bytes touched: 1, 2 or WORD_BYTES
    logic [LANE_BITS-1:0]  acc_low_mask;  // address bits that must be zero
    logic [LANE_BITS-1:0]  acc_off;       // aligned lane of the MS byte
    logic [LANE_BITS:0]    acc_shift;     // byte positions below the access
    logic [ROW_BITS-1:0]   acc_row;
    logic [WORD_WIDTH-1:0] acc_wword;     // write data placed in word position
    logic                  acc_misaligned;
    logic                  acc_write;
    logic                  acc_read;

    assign req_ok = i_req_valid && (state_reg == ST_IDLE);

    always_comb begin
        acc_bytes = FULL_BYTES;
        case (i_size)
            2'b00:   acc_bytes = NB_ONE;
            2'b01:   acc_bytes = NB_TWO;
            default: acc_bytes = FULL_BYTES;
        endcase
    end

    assign acc_low_mask = LANE_BITS'(acc_bytes - NB_ONE);
    assign acc_off      = i_addr[LANE_BITS-1:0] & ~acc_low_mask;
    assign acc_row      = i_addr[ADDR_WIDTH-1:LANE_BITS];
    // Big-endian: the accessed unit occupies byte positions
    // [acc_shift, acc_shift + acc_bytes) counted from the word's LSB.
    assign acc_shift    = FULL_BYTES - {1'b0, acc_off} - acc_bytes;
    assign acc_wword    = i_wdata << (int'(acc_shift) * BYTE_WIDTH);

`ifdef RAM_MISALIGN_CHECK_EN
    logic misaligned_reg;

    assign acc_misaligned = |(i_addr[LANE_BITS-1:0] & acc_low_mask);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            misaligned_reg <= 1'b0;
        end else begin
            misaligned_reg <= req_ok && acc_misaligned;
        end
    end

    assign o_misaligned = misaligned_reg;
`else
    assign acc_misaligned = 1'b0;
    assign o_misaligned   = 1'b0;
`endif

    assign acc_write = req_ok && i_we && !acc_misaligned;
    assign acc_read  = req_ok && !i_we && !acc_misaligned;

    // -----------------------------------------------------------------------
    // Byte lanes
    // -----------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] rd_word;

    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        logic [BYTE_WIDTH-1:0] mem [ROWS];
        logic [BYTE_WIDTH-1:0] rd_q;
        logic                  lane_hit;
        logic                  lane_we;
        logic [ROW_BITS-1:0]   lane_row;
        logic [BYTE_WIDTH-1:0] lane_wdata;

        assign lane_hit = ({1'b0, acc_off} <= (LANE_BITS + 1)'(gi)) &&
                          ((LANE_BITS + 1)'(gi) < ({1'b0, acc_off} + acc_bytes));

        // The loader owns the single port while in LOAD; otherwise the
        // access port drives it.
        always_comb begin
            lane_we    = 1'b0;
            lane_row   = acc_row;
            lane_wdata = acc_wword[(WORD_BYTES-1-gi)*BYTE_WIDTH +: BYTE_WIDTH];
            if (state_reg == ST_LOAD) begin
                lane_row   = ptr_reg[ADDR_WIDTH-1:LANE_BITS];
                lane_wdata = i_load_byte;
                lane_we    = load_we && (ptr_reg[LANE_BITS-1:0] == LANE_BITS'(gi));
            end else begin
                lane_we = acc_write && lane_hit;
            end
            if (i_reset) begin
                lane_we = 1'b0;
            end
        end

        always_ff @(posedge i_clk) begin
            if (lane_we) begin
                mem[lane_row] <= lane_wdata;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                rd_q <= '0;
            end else if (acc_read) begin
                rd_q <= mem[lane_row];
            end
        end

        assign rd_word[(WORD_BYTES-1-gi)*BYTE_WIDTH +: BYTE_WIDTH] = rd_q;
    end

    // -----------------------------------------------------------------------
    // Read alignment and extension. The controls only change on an accepted
    // read, so o_rdata holds between reads.
    // -----------------------------------------------------------------------
    logic [LANE_BITS:0]    rd_shift_q;
    logic [LANE_BITS:0]    rd_bytes_q;
    logic                  rd_unsigned_q;
    logic                  rvalid_reg;
    logic [WORD_WIDTH-1:0] rd_aligned;
    logic [WORD_WIDTH-1:0] rd_keep;
    logic [WORD_WIDTH-1:0] rd_sign_word;
    logic                  rd_fill;
    int                    rd_bits;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_shift_q    <= '0;
            rd_bytes_q    <= FULL_BYTES;
            rd_unsigned_q <= 1'b1;
            rvalid_reg    <= 1'b0;
        end else begin
            rvalid_reg <= acc_read;
            if (acc_read) begin
                rd_shift_q    <= acc_shift;
                rd_bytes_q    <= acc_bytes;
                rd_unsigned_q <= i_unsigned;
            end
        end
    end

    always_comb begin
        rd_bits      = int'(rd_bytes_q) * BYTE_WIDTH;
        rd_aligned   = rd_word >> (int'(rd_shift_q) * BYTE_WIDTH);
        // Shifting by the full width yields zero, so a word keeps every bit.
        rd_keep      = ~({WORD_WIDTH{1'b1}} << rd_bits);
        rd_sign_word = rd_aligned >> (rd_bits - 1);
        rd_fill      = !rd_unsigned_q && rd_sign_word[0];
        o_rdata      = (rd_aligned & rd_keep) | ({WORD_WIDTH{rd_fill}} & ~rd_keep);
    end

    assign o_rvalid = rvalid_reg;

endmodule

// File: tb/tb_byte_ram_sync_loader.sv
module tb_byte_ram_sync_loader;

    localparam int AW    = 12;
    localparam int BW    = 8;
    localparam int WB    = 4;
    localparam int DEPTH = 2 ** AW;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_load_start;
    logic [AW:0]   i_load_count;
    logic          i_load_valid;
    logic [BW-1:0] i_load_byte;
    logic          o_load_ready;
    logic          o_load_done;
    logic          o_busy;
    logic          i_req_valid;
    logic          i_we;
    logic [1:0]    i_size;
    logic          i_unsigned;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_wdata;
    logic [31:0]   o_rdata;
    logic          o_rvalid;
    logic          o_misaligned;

    always #5 i_clk = ~i_clk;

    byte_ram_sync_loader #(
        .ADDR_WIDTH(AW),
        .BYTE_WIDTH(BW),
        .WORD_BYTES(WB)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load_start(i_load_start),
        .i_load_count(i_load_count),
        .i_load_valid(i_load_valid),
        .i_load_byte (i_load_byte),
        .o_load_ready(o_load_ready),
        .o_load_done (o_load_done),
        .o_busy      (o_busy),
        .i_req_valid (i_req_valid),
        .i_we        (i_we),
        .i_size      (i_size),
        .i_unsigned  (i_unsigned),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_rvalid    (o_rvalid),
        .o_misaligned(o_misaligned)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [0:DEPTH-1];
    logic [31:0] last_rdata;
    logic [31:0] last_got;
    logic [7:0]  load_q [$];

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        if (size == 2'b00) return 1;
        if (size == 2'b01) return 2;
        return WB;
    endfunction

    // Big-endian assembly of n bytes from the byte array, then extension.
    function automatic logic [31:0] model_read(input int addr, input logic [1:0] size, input bit uns);
        int          n;
        int          base;
        logic [31:0] v;
        n    = size_bytes(size);
        base = addr - (addr % n);
        v    = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[base + i]);
        if (n < WB && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic junk_req();
        i_req_valid = 1'b1;
        i_we        = 1'($urandom);
        i_addr      = AW'($urandom);
        i_size      = 2'($urandom);
        i_unsigned  = 1'($urandom);
        i_wdata     = $urandom;
    endtask

    task automatic access(input string tag, input bit we, input int addr,
                          input logic [1:0] size, input bit uns, input logic [31:0] wdata);
        int n;
        int base;
        bit mis;
        n   = size_bytes(size);
        mis = 1'b0;
`ifdef RAM_MISALIGN_CHECK_EN
        mis = (addr % n) != 0;
`endif
        base        = addr - (addr % n);
        i_req_valid = 1'b1;
        i_we        = we;
        i_addr      = addr[AW-1:0];
        i_size      = size;
        i_unsigned  = uns;
        i_wdata     = wdata;
        step();
        i_req_valid = 1'b0;
        if (!we && !mis) begin
            last_rdata = model_read(addr, size, uns);
        end else if (we && !mis) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wdata >> (8 * (n - 1 - i)));
        end
        chk({tag, "_mis"}, o_misaligned, mis);
        chk({tag, "_rvalid"}, o_rvalid, !we && !mis);
        chk({tag, "_rdata"}, o_rdata, last_rdata);
        last_got = o_rdata;
        step();
        chk({tag, "_pulse_end"}, {o_rvalid, o_misaligned}, 0);
        chk({tag, "_hold"}, o_rdata, last_rdata);
    endtask

    task automatic do_load(input string tag, input int count, input bit gaps);
        int         n;
        logic [7:0] b;
        n            = (count > DEPTH) ? DEPTH : count;
        i_req_valid  = 1'b0;
        i_load_count = (AW + 1)'(count);
        i_load_start = 1'b1;
        step();
        i_load_start = 1'b0;
        chk({tag, "_busy"}, o_busy, 1);
        chk({tag, "_ready"}, o_load_ready, n != 0);
        chk({tag, "_done0"}, o_load_done, n == 0);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                i_load_valid = 1'b0;
                i_load_byte  = 8'($urandom);
                junk_req();
                step();
                chk({tag, "_gap_ready"}, o_load_ready, 1);
                chk({tag, "_gap_done"}, o_load_done, 0);
            end
            b            = (load_q.size() != 0) ? load_q.pop_front() : 8'($urandom);
            i_load_valid = 1'b1;
            i_load_byte  = b;
            junk_req();
            step();
            ref_mem[i] = b;
            chk({tag, "_done"}, o_load_done, i == n - 1);
            chk({tag, "_drop"}, {o_rvalid, o_misaligned}, 0);
            chk({tag, "_hold"}, o_rdata, last_rdata);
            if (i == n - 1) chk({tag, "_ready_in_done"}, o_load_ready, 0);
        end
        i_load_valid = 1'b0;
        junk_req();
        step();
        i_req_valid = 1'b0;
        chk({tag, "_idle"}, {o_busy, o_load_ready, o_load_done}, 0);
        chk({tag, "_drop_done"}, {o_rvalid, o_misaligned}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset      = 1'b1;
        i_load_start = 1'b0;
        i_load_count = '0;
        i_load_valid = 1'b0;
        i_load_byte  = '0;
        i_req_valid  = 1'b0;
        i_we         = 1'b0;
        i_size       = 2'b00;
        i_unsigned   = 1'b0;
        i_addr       = '0;
        i_wdata      = '0;
        last_rdata   = '0;
        step();
        step();
        chk("rst_flags", {o_load_ready, o_load_done, o_busy, o_rvalid, o_misaligned}, 0);
        chk("rst_rdata", o_rdata, 0);
        i_reset = 1'b0;
        step();
        chk("idle_flags", {o_load_ready, o_load_done, o_busy}, 0);

        // Eight-byte load, then big-endian word reads.
        for (int i = 1; i <= 8; i++) load_q.push_back(8'(i));
        do_load("load8", 8, 1'b0);
        access("rd_w0", 1'b0, 0, 2'b10, 1'b0, 32'h0);
        chk("rd_w0_val", last_got, 32'h0102_0304);
        access("rd_w4", 1'b0, 4, 2'b10, 1'b0, 32'h0);
        chk("rd_w4_val", last_got, 32'h0506_0708);

        // Byte write, sign/zero-extended reads.
        access("wr_b3", 1'b1, 3, 2'b00, 1'b0, 32'h1234_5680);
        access("rd_b3_s", 1'b0, 3, 2'b00, 1'b0, 32'h0);
        chk("rd_b3_s_val", last_got, 32'hFFFF_FF80);
        access("rd_b3_u", 1'b0, 3, 2'b00, 1'b1, 32'h0);
        chk("rd_b3_u_val", last_got, 32'h0000_0080);
        access("rd_h2_s", 1'b0, 2, 2'b01, 1'b0, 32'h0);
        chk("rd_h2_s_val", last_got, 32'h0000_0380);

        // Half write and word read-back.
        access("wr_h6", 1'b1, 6, 2'b01, 1'b0, 32'hDEAD_BEEF);
        access("rd_w4b", 1'b0, 4, 2'b10, 1'b0, 32'h0);
        chk("rd_w4b_val", last_got, 32'h0506_BEEF);

        // Misaligned word write.
        access("wr_w5", 1'b1, 5, 2'b10, 1'b0, 32'hA1B2_C3D4);
        access("rd_w4c", 1'b0, 4, 2'b10, 1'b0, 32'h0);
`ifdef RAM_MISALIGN_CHECK_EN
        chk("rd_w4c_val", last_got, 32'h0506_BEEF);
`else
        chk("rd_w4c_val", last_got, 32'hA1B2_C3D4);
`endif

        // Loader with gaps, then an empty session.
        do_load("gap3", 3, 1'b1);
        access("rd_gap", 1'b0, 0, 2'b10, 1'b0, 32'h0);
        do_load("zero", 0, 1'b0);
        access("rd_zero", 1'b0, 0, 2'b10, 1'b1, 32'h0);

        // Reset after two of four bytes.
        i_load_count = (AW + 1)'(4);
        i_load_start = 1'b1;
        step();
        i_load_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_load_valid = 1'b1;
            i_load_byte  = 8'(8'hA0 + k);
            step();
            ref_mem[k] = 8'(8'hA0 + k);
        end
        i_load_valid = 1'b0;
        i_reset      = 1'b1;
        step();
        i_reset    = 1'b0;
        last_rdata = '0;
        chk("midrst_flags", {o_load_ready, o_load_done, o_busy}, 0);
        chk("midrst_rdata", o_rdata, 0);
        do_load("restart", 0, 1'b0);
        access("rd_midrst", 1'b0, 0, 2'b10, 1'b0, 32'h0);

        // Oversized count clamps to the full depth.
        do_load("full", 8191, 1'b0);
        access("rd_last", 1'b0, DEPTH - 4, 2'b10, 1'b0, 32'h0);

        // Randomised accesses over the whole, now initialised, memory.
        for (int t = 0; t < 300; t++) begin
            access("rand", 1'($urandom), int'($urandom_range(0, DEPTH - 1)),
                   2'($urandom), 1'($urandom), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
